sigmoid_sched: RTL and testbench

- Round-robin scheduler that shares one multi-cycle sigmoid_approx instance among NUM_REQ neuron requesters in the NN datapath.
- Accepts one FP operand at a time and issues it to the sigmoid unit with a single-cycle in_valid pulse.
- Holds the operand stable for the whole operation, captures the registered result, and returns it to the originating requester with its ID.
- A watchdog aborts a hung operation and returns a quiet NaN.

---
 rtl/sigmoid_sched_if.sv | 23 ++
 rtl/sigmoid_sched.sv | 139 +++++++++++++
 tb/tb_sigmoid_sched.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sigmoid_sched_if.sv
// Requester-side bus of the sigmoid scheduler: per-requester operand handshake
// and the shared one-hot response channel.
interface sigmoid_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int W       = 32
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*W-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [W-1:0]         rsp_data;
  logic                 rsp_err;

  modport master (
    output req_valid, req_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/sigmoid_sched.sv
// Round-robin arbiter that time-shares one multi-cycle sigmoid unit among
// NUM_REQ requesters, with a watchdog that answers a hung operation with a quiet NaN.
module sigmoid_sched #(
  parameter int NUM_REQ    = 4,
  parameter int exp_width  = 8,
  parameter int mant_width = 24,
  parameter int TIMEOUT    = 64,
  localparam int W   = exp_width + mant_width,
  localparam int IDW = $clog2(NUM_REQ),
  localparam int TW  = $clog2(TIMEOUT)
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic [2:0]    round_mode,
  sigmoid_sched_if.slave req_bus,
  output logic          busy,
  output logic [W-1:0]  sig_in_x,
  output logic          sig_in_valid,
  output logic [2:0]    sig_round_mode,
  input  logic          sig_out_valid,
  input  logic [W-1:0]  sig_result
);

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, CAPTURE, RESPOND} state_t;

  localparam logic [W-1:0] QNAN = {1'b0, {exp_width{1'b1}}, 1'b1, {(mant_width-2){1'b0}}};

  state_t             state;
  logic [IDW-1:0]     rr_ptr;
  logic [TW-1:0]      timer;
  logic [W-1:0]       x_reg;
  logic [IDW-1:0]     id_reg;
  logic [2:0]         mode_reg;
  logic               sig_in_valid_reg;
  logic               busy_reg;
  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic [W-1:0]       rsp_data_reg;
  logic               rsp_err_reg;

  // Candidate requester for each search position, rotated to start at rr_ptr.
  logic [IDW-1:0] cand [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDW:0] sum;
      assign sum      = {1'b0, rr_ptr} + (IDW+1)'(gi);
      assign cand[gi] = (sum >= (IDW+1)'(NUM_REQ)) ? IDW'(sum - (IDW+1)'(NUM_REQ))
                                                   : sum[IDW-1:0];
    end
  endgenerate

  logic           grant_found;
  logic [IDW-1:0] grant_idx;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_bus.req_valid[cand[k]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[k];
      end
    end
  end

  always_comb begin
    req_bus.req_ready = '0;
    if (state == IDLE && grant_found) begin
      req_bus.req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      timer            <= '0;
      x_reg            <= '0;
      id_reg           <= '0;
      mode_reg         <= '0;
      sig_in_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
      rsp_valid_reg    <= '0;
      rsp_data_reg     <= '0;
      rsp_err_reg      <= 1'b0;
    end else begin
      rsp_valid_reg <= '0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            x_reg            <= req_bus.req_data[int'(grant_idx)*W +: W];
            id_reg           <= grant_idx;
            mode_reg         <= round_mode;
            sig_in_valid_reg <= 1'b1;
            busy_reg         <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          sig_in_valid_reg <= 1'b0;
          timer            <= '0;
          state            <= BUSY;
        end
        BUSY: begin
          timer <= timer + 1'b1;
          // A result arriving on the last allowed cycle still wins over the abort.
          if (sig_out_valid) begin
            state <= CAPTURE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_data_reg <= QNAN;
            rsp_err_reg  <= 1'b1;
            state        <= RESPOND;
          end
        end
        CAPTURE: begin
          rsp_data_reg <= sig_result;
          rsp_err_reg  <= 1'b0;
          state        <= RESPOND;
        end
        RESPOND: begin
          rsp_valid_reg[id_reg] <= 1'b1;
          rr_ptr   <= (id_reg == IDW'(NUM_REQ - 1)) ? '0 : id_reg + 1'b1;
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sig_in_x          = x_reg;
  assign sig_in_valid      = sig_in_valid_reg;
  assign sig_round_mode    = mode_reg;
  assign busy              = busy_reg;
  assign req_bus.rsp_valid = rsp_valid_reg;
  assign req_bus.rsp_data  = rsp_data_reg;
  assign req_bus.rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_sigmoid_sched.sv
// Directed bench for sigmoid_sched with a behavioural sigmoid unit of
// programmable latency (result = x ^ 32'h3F000000, so x=0 gives 0.5).
module tb_sigmoid_sched;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [2:0]  round_mode = 3'd1;
  logic        busy;
  logic [31:0] sig_in_x;
  logic        sig_in_valid;
  logic [2:0]  sig_round_mode;
  logic        sig_out_valid;
  logic [31:0] sig_result;

  int checks = 0;
  int errors = 0;

  sigmoid_sched_if #(.NUM_REQ(4), .W(32)) bus ();

  sigmoid_sched #(.NUM_REQ(4), .exp_width(8), .mant_width(24), .TIMEOUT(64)) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .round_mode     (round_mode),
    .req_bus        (bus),
    .busy           (busy),
    .sig_in_x       (sig_in_x),
    .sig_in_valid   (sig_in_valid),
    .sig_round_mode (sig_round_mode),
    .sig_out_valid  (sig_out_valid),
    .sig_result     (sig_result)
  );

  always #5 clk = ~clk;

  // Behavioural sigmoid unit: out_valid lat cycles after in_valid (lat=0: never).
  int   lat = 1;
  int   cnt;
  bit   armed;
  logic model_valid;
  logic manual_valid = 1'b0;

  assign sig_out_valid = model_valid | manual_valid;

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      model_valid <= 1'b0;
      armed       <= 1'b0;
      cnt         <= 0;
      sig_result  <= '0;
    end else begin
      if (model_valid) sig_result <= sig_in_x ^ 32'h3F00_0000;
      model_valid <= 1'b0;
      if (sig_in_valid) begin
        armed       <= (lat > 1);
        cnt         <= lat - 1;
        model_valid <= (lat == 1);
      end else if (armed) begin
        if (cnt == 1) begin
          model_valid <= 1'b1;
          armed       <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Operand must stay put from the issue cycle until the response appears.
  logic [31:0] held_x;
  bit          in_win = 1'b0;

  always @(negedge clk) begin
    if (!rst_l) begin
      in_win = 1'b0;
    end else if (sig_in_valid) begin
      held_x = sig_in_x;
      in_win = 1'b1;
    end else if (in_win) begin
      chk("x_stable", sig_in_x, held_x);
      if (|bus.rsp_valid) in_win = 1'b0;
    end
  end

  // Called at the accept cycle; returns cycles from accept to rsp_valid.
  task automatic do_op(input string tag, input logic [3:0] exp_grant, input bit hold,
                       input int max, output int n);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'(exp_grant));
    @(negedge clk); #1;
    n = 1;
    if (!hold) bus.req_valid = '0;
    chk({tag, "_in_valid"}, 32'(sig_in_valid), 32'd1);
    chk({tag, "_ready_off"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_mode"}, 32'(sig_round_mode), 32'(round_mode));
    while (bus.rsp_valid == '0 && n < max) begin
      @(negedge clk); #1;
      n++;
    end
    $display("op %s grant %b rsp_valid %b data %h err %b after %0d cycles",
             tag, exp_grant, bus.rsp_valid, bus.rsp_data, bus.rsp_err, n);
  endtask

  logic [3:0]  rr_grant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [31:0] rr_data  [5] = '{32'h7F00_0000, 32'h8080_0000, 32'h0080_0000,
                                32'hFF00_0000, 32'h7F00_0000};

  initial begin
    int n;
    int hits;
    bus.req_valid = '0;
    bus.req_data  = '0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_valid", 32'(sig_in_valid), 32'd0);
    chk("rst_in_x", sig_in_x, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    rst_l = 1'b1;
    @(negedge clk); #1;

    // Round robin with all requesters held active
    lat = 3;
    bus.req_data  = {32'hC000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000};
    bus.req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      do_op("rr", rr_grant[i], 1'b1, 40, n);
      chk("rr_latency", 32'(n), 32'd7);
      chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'(rr_grant[i]));
      chk("rr_rsp_data", bus.rsp_data, rr_data[i]);
    end
    bus.req_valid = '0;
    @(negedge clk); #1;
    chk("rr_rsp_pulse", 32'(bus.rsp_valid), 32'd0);

    // Single request on requester 2, x=0, L=10
    lat = 10;
    bus.req_data  = '0;
    bus.req_valid = 4'b0100;
    #1;
    do_op("single", 4'b0100, 1'b0, 40, n);
    chk("single_latency", 32'(n), 32'd14);
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h4);
    chk("single_rsp_data", bus.rsp_data, 32'h3F00_0000);
    chk("single_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk); #1;
    chk("single_rsp_pulse", 32'(bus.rsp_valid), 32'd0);

    // Requester 1 completes, leaving rr_ptr=2; then 0011 must grant 0 before 1
    lat = 1;
    bus.req_data  = {32'h0, 32'h0, 32'h3E80_0000, 32'h3F00_0000};
    bus.req_valid = 4'b0010;
    #1;
    do_op("req1", 4'b0010, 1'b0, 40, n);
    chk("req1_latency", 32'(n), 32'd5);
    chk("req1_rsp_data", bus.rsp_data, 32'h0180_0000);
    @(negedge clk); #1;
    bus.req_valid = 4'b0011;
    #1;
    do_op("wrap0", 4'b0001, 1'b1, 40, n);
    chk("wrap0_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("wrap0_rsp_data", bus.rsp_data, 32'h0000_0000);
    do_op("wrap1", 4'b0010, 1'b0, 40, n);
    chk("wrap1_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    chk("wrap1_rsp_data", bus.rsp_data, 32'h0180_0000);
    @(negedge clk); #1;

    // Timeout: unit never answers
    lat = 0;
    bus.req_data  = {32'h1234_5678, 96'h0};
    bus.req_valid = 4'b1000;
    #1;
    do_op("tmo", 4'b1000, 1'b0, 100, n);
    chk("tmo_latency", 32'(n), 32'd67);
    chk("tmo_rsp_valid", 32'(bus.rsp_valid), 32'h8);
    chk("tmo_rsp_data", bus.rsp_data, 32'h7FC0_0000);
    chk("tmo_rsp_err", 32'(bus.rsp_err), 32'd1);
    @(negedge clk); #1;
    manual_valid = 1'b1;
    @(negedge clk); #1;
    manual_valid = 1'b0;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid != '0) hits++;
    end
    chk("late_no_rsp", 32'(hits), 32'd0);
    chk("late_busy", 32'(busy), 32'd0);

    // Result on the same cycle as the timeout: normal capture wins
    lat = 64;
    bus.req_data  = {96'h0, 32'hBF00_0000};
    bus.req_valid = 4'b0001;
    #1;
    do_op("edge", 4'b0001, 1'b0, 100, n);
    chk("edge_latency", 32'(n), 32'd68);
    chk("edge_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("edge_rsp_data", bus.rsp_data, 32'h8000_0000);
    chk("edge_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk); #1;

    // Reset while BUSY discards the operation
    lat = 10;
    bus.req_data  = {32'h0, 32'h4040_0000, 64'h0};
    bus.req_valid = 4'b0100;
    #1;
    chk("mid_ready", 32'(bus.req_ready), 32'h4);
    @(negedge clk); #1;
    bus.req_valid = '0;
    repeat (4) begin @(negedge clk); #1; end
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst_l = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_x", sig_in_x, 32'd0);
    chk("mid_rst_in_valid", 32'(sig_in_valid), 32'd0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_rsp_data", bus.rsp_data, 32'd0);
    chk("mid_rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk); #1;
    rst_l = 1'b1;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid != '0) hits++;
    end
    chk("mid_lost_no_rsp", 32'(hits), 32'd0);
    lat = 2;
    bus.req_data  = {32'h0, 32'h0, 32'h0, 32'h3F40_0000};
    bus.req_valid = 4'b1111;
    #1;
    do_op("post_rst", 4'b0001, 1'b0, 40, n);
    chk("post_rst_latency", 32'(n), 32'd6);
    chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("post_rst_rsp_data", bus.rsp_data, 32'h0040_0000);
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
